// File: rtl/switch_debouncer_pkg.sv
// Board constants shared by the switch debouncer and its per-channel block.
package switch_debouncer_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_MS         = 1;
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One debounce lane: synchroniser chain, stability counter, registered edge pulses.
module switch_debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit INIT            = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // Metastability chain: raw input shifts in at bit 0, only the last stage is used.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= {SYNC_STAGES{INIT}};
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Accept a new level only after it differs from the current one for
  // DEBOUNCE_CYCLES consecutive edges; any return to the old level restarts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      level <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= s;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch/button debouncer: independent lanes plus a combined edge flag.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int CHANNELS        = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit INIT            = 1'b0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] asyncn,
  output logic [CHANNELS-1:0] syncn,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_edge
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    switch_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (INIT)
    ) u_ch (
      .clk   (clk),
      .resetn(resetn),
      .din   (asyncn[i]),
      .level (syncn[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Pulses are registered per lane, so this OR adds no path from asyncn.
  assign any_edge = |(rise | fall);

endmodule
